// File: rtl/minibyte_io_responder_if.sv
// minibyte_io_responder_if: minibyte responder bus (addr_in/data_in/we_in from CPU, data_out/hit_out back).
interface minibyte_io_responder_if;
  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic [7:0] data_out;
  logic       hit_out;
  modport master (output addr_in, data_in, we_in, input data_out, hit_out);
  modport slave  (input addr_in, data_in, we_in, output data_out, hit_out);
endinterface

// File: rtl/minibyte_io_responder.sv
// minibyte_io_responder: 8-byte window peripheral (GPIO out/in, prescaled timer, status, scratch, ID).
// Ports: clk_in/rst_in (async active-low), bus (slave modport), gpio_in (async), gpio_out, irq_out.
// Optional: define MINIBYTE_RESP_IN_EDGE_EN for rising-edge detect on gpio_in[0] (STATUS bit2 / TMR_CTL bit6).
module minibyte_io_responder #(
  parameter logic [6:0] BASE_ADDR = 7'h70,
  parameter logic [7:0] ID_VALUE  = 8'hB5
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  minibyte_io_responder_if.slave        bus,
  input  logic [7:0]                    gpio_in,
  output logic [7:0]                    gpio_out,
  output logic                          irq_out
);
`ifdef MINIBYTE_RESP_IN_EDGE_EN
  localparam logic [7:0] CTL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTL_MASK = 8'hBF;
`endif
  logic [7:0] out_q, out_d, sync1_q, sync2_q, cnt_q, cnt_d, cmp_q, cmp_d;
  logic [7:0] ctl_q, ctl_d, scratch_q, scratch_d;
  logic [6:0] pre_q, pre_d, mask;
  logic       cmpf_q, cmpf_d, ovf_q, ovf_d, edgef_q;
  logic [2:0] off;
  logic       hit, wr, tick, ld_cnt, wr_stat, wr_ctl;
  always_comb begin
    off     = bus.addr_in[2:0];
    hit     = bus.addr_in[6:3] == BASE_ADDR[6:3];
    wr      = bus.we_in & hit;
    ld_cnt  = wr && off == 3'd2;
    wr_ctl  = wr && off == 3'd4;
    wr_stat = wr && off == 3'd5;
    mask    = 7'((8'd1 << ctl_q[3:1]) - 8'd1);
    tick    = ctl_q[0] && ((pre_q & mask) == mask);
    out_d     = (wr && off == 3'd0) ? bus.data_in : out_q;
    cmp_d     = (wr && off == 3'd3) ? bus.data_in : cmp_q;
    ctl_d     = wr_ctl ? (bus.data_in & CTL_MASK) : ctl_q;
    scratch_d = (wr && off == 3'd6) ? bus.data_in : scratch_q;
    pre_d     = (!ctl_q[0] || wr_ctl) ? 7'd0 : pre_q + 7'd1;
    // A CPU load of the count suppresses that cycle's tick entirely (no increment, no flags).
    cnt_d  = ld_cnt ? bus.data_in :
             !tick  ? cnt_q :
             (ctl_q[7] && cnt_q == cmp_q) ? 8'h00 : cnt_q + 8'd1;
    cmpf_d = (tick && !ld_cnt && cnt_q == cmp_q) | (cmpf_q & ~(wr_stat & bus.data_in[0]));
    ovf_d  = (tick && !ld_cnt && cnt_q == 8'hFF) | (ovf_q & ~(wr_stat & bus.data_in[1]));
  end
  always_comb begin
    bus.hit_out  = hit;
    bus.data_out = 8'h00;
    if (hit)
      case (off)
        3'd0:    bus.data_out = out_q;
        3'd1:    bus.data_out = sync2_q;
        3'd2:    bus.data_out = cnt_q;
        3'd3:    bus.data_out = cmp_q;
        3'd4:    bus.data_out = ctl_q;
        3'd5:    bus.data_out = {5'd0, edgef_q, ovf_q, cmpf_q};
        3'd6:    bus.data_out = scratch_q;
        default: bus.data_out = ID_VALUE;
      endcase
  end
  assign gpio_out = out_q;
  assign irq_out  = (cmpf_q & ctl_q[4]) | (ovf_q & ctl_q[5]) | (edgef_q & ctl_q[6]);
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      out_q     <= 8'h00;
      sync1_q   <= 8'h00;
      sync2_q   <= 8'h00;
      cnt_q     <= 8'h00;
      cmp_q     <= 8'hFF;
      ctl_q     <= 8'h00;
      scratch_q <= 8'h00;
      pre_q     <= 7'd0;
      cmpf_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctl_q     <= ctl_d;
      scratch_q <= scratch_d;
      pre_q     <= pre_d;
      cmpf_q    <= cmpf_d;
      ovf_q     <= ovf_d;
    end
`ifdef MINIBYTE_RESP_IN_EDGE_EN
  logic edge_q, edgef_d;
  // Rising edge of the synchronized bit; set beats a simultaneous W1C.
  always_comb edgef_d = (sync2_q[0] & ~edge_q) | (edgef_q & ~(wr_stat & bus.data_in[2]));
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      edge_q  <= 1'b0;
      edgef_q <= 1'b0;
    end else begin
      edge_q  <= sync2_q[0];
      edgef_q <= edgef_d;
    end
`else
  assign edgef_q = 1'b0;
`endif
endmodule

// File: tb/tb_minibyte_io_responder.sv
// tb_minibyte_io_responder: randomized bench against a spec-level reference model.
module tb_minibyte_io_responder;
  localparam int BASE = 'h70;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic [7:0] gpio_in = 8'h00, gpio_out;
  logic irq_out;
  int checks = 0, errors = 0;
  minibyte_io_responder_if bus();
  minibyte_io_responder dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave),
                             .gpio_in(gpio_in), .gpio_out(gpio_out), .irq_out(irq_out));
  always #5 clk_in = ~clk_in;
  int m_out, m_s1, m_s2, m_cnt, m_cmp, m_ctl, m_scr, m_pre;
  bit m_cmpf, m_ovf, m_edgef, m_e3;
  logic [7:0] last_rd;
  logic last_hit;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_out = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_cmp = 255; m_ctl = 0; m_scr = 0; m_pre = 0;
    m_cmpf = 0; m_ovf = 0; m_edgef = 0; m_e3 = 0;
  endfunction
  function automatic bit in_win(input int a);
    return a >= BASE && a <= BASE + 7;
  endfunction
  function automatic int exp_read(input int a);
    if (!in_win(a)) return 0;
    case (a - BASE)
      0: return m_out;
      1: return m_s2;
      2: return m_cnt;
      3: return m_cmp;
      4: return m_ctl;
      5: return (int'(m_edgef) << 2) | (int'(m_ovf) << 1) | int'(m_cmpf);
      6: return m_scr;
      default: return 'hB5;
    endcase
  endfunction
  function automatic bit exp_irq();
    return (m_cmpf && m_ctl[4]) || (m_ovf && m_ctl[5]) || (m_edgef && m_ctl[6]);
  endfunction
  function automatic void model_step(input int a, input int d, input bit w, input int g);
    int per, off, ncnt, clr;
    bit wr, tick, cs, os, rise;
    per  = 1 << ((m_ctl >> 1) & 7);
    wr   = w && in_win(a);
    off  = a - BASE;
    tick = m_ctl[0] && (m_pre % per == per - 1);
    ncnt = m_cnt; cs = 0; os = 0;
    if (wr && off == 2) ncnt = d;
    else if (tick) begin
      cs = m_cnt == m_cmp;
      os = m_cnt == 255;
      ncnt = (m_ctl[7] && m_cnt == m_cmp) ? 0 : (m_cnt + 1) % 256;
    end
    clr = (wr && off == 5) ? d : 0;
    m_cmpf = cs || (m_cmpf && !clr[0]);
    m_ovf  = os || (m_ovf && !clr[1]);
`ifdef MINIBYTE_RESP_IN_EDGE_EN
    rise = m_s2[0] && !m_e3;
    m_edgef = rise || (m_edgef && !clr[2]);
    m_e3 = m_s2[0];
`else
    rise = 0;
    m_edgef = rise;
`endif
    m_pre = (!m_ctl[0] || (wr && off == 4)) ? 0 : (m_pre + 1) % 128;
    m_s2 = m_s1;
    m_s1 = g;
    m_cnt = ncnt;
    if (wr && off == 0) m_out = d;
    if (wr && off == 3) m_cmp = d;
`ifdef MINIBYTE_RESP_IN_EDGE_EN
    if (wr && off == 4) m_ctl = d;
`else
    if (wr && off == 4) m_ctl = d & 'hBF;
`endif
    if (wr && off == 6) m_scr = d;
  endfunction
  task automatic cyc(input int a, input int d, input bit w, input int g);
    bus.addr_in = 7'(a); bus.data_in = 8'(d); bus.we_in = w; gpio_in = 8'(g);
    #1;
    last_rd = bus.data_out;
    last_hit = bus.hit_out;
    chk("hit", {31'd0, bus.hit_out}, {31'd0, in_win(a)});
    chk("rdata", {24'd0, bus.data_out}, exp_read(a));
    chk("gpio_out", {24'd0, gpio_out}, m_out);
    chk("irq", {31'd0, irq_out}, {31'd0, exp_irq()});
    @(posedge clk_in);
    model_step(a, d, w, g);
    #1;
  endtask
  initial begin
    logic [7:0] rst_exp [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hB5};
    int g, a, d;
    bit w;
    bus.addr_in = 7'h70; bus.data_in = 8'h00; bus.we_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(BASE + i, 0, 0, 0);
      chk("rst_read", {24'd0, last_rd}, {24'd0, rst_exp[i]});
    end
    cyc('h6F, 'hAA, 1, 0);
    chk("miss_lo", {23'd0, last_hit, last_rd}, 0);
    cyc('h78, 'hAA, 1, 0);
    chk("miss_hi", {23'd0, last_hit, last_rd}, 0);
    cyc('h70, 'h5A, 1, 0);
    chk("gpio_out_5a", {24'd0, gpio_out}, 'h5A);
    cyc('h71, 0, 0, 'h3C);
    cyc('h71, 0, 0, 'h3C);
    chk("in_port_1st", {24'd0, last_rd}, 'h00);
    cyc('h71, 'hFF, 1, 'h3C);
    chk("in_port_2nd", {24'd0, last_rd}, 'h3C);
    cyc('h71, 0, 0, 'h3C);
    chk("in_port_ro", {24'd0, last_rd}, 'h3C);
    cyc('h73, 3, 1, 'h3C);
    cyc('h74, 'h91, 1, 'h3C);
    for (int i = 0; i < 12; i++) cyc('h72, 0, 0, 'h3C);
    cyc('h75, 1, 1, 'h3C);
    for (int i = 0; i < 4; i++) cyc('h75, 0, 0, 'h3C);
    for (int i = 0; i < 3; i++) cyc('h75, 1, 1, 'h3C);
    cyc('h72, 'hFE, 1, 'h3C);
    cyc('h74, 'h25, 1, 'h3C);
    for (int i = 0; i < 14; i++) cyc('h72, 0, 0, 'h3C);
    cyc('h72, 'h10, 1, 'h3C);
    for (int i = 0; i < 6; i++) cyc('h72, 0, 0, 'h3C);
    cyc('h74, 'h40, 1, 'h00);
    for (int i = 0; i < 4; i++) cyc('h75, 0, 0, 'h00);
    for (int i = 0; i < 5; i++) cyc('h75, 0, 0, 'h01);
    cyc('h75, 4, 1, 'h01);
    cyc('h75, 0, 0, 'h01);
    g = 'h01;
    for (int i = 0; i < 4000; i++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range('h68, 'h7F)) : BASE + int'($urandom_range(0, 7));
      w = $urandom_range(0, 3) == 0;
      d = int'($urandom_range(0, 255));
      if (a == BASE + 4) d = (d & 'hF6) | ($urandom_range(0, 7) != 0 ? 1 : 0);
      if ($urandom_range(0, 15) == 0) g = int'($urandom_range(0, 255));
      cyc(a, d, w, g);
      if (i == 2000) begin
        rst_in = 1'b0;
        #1;
        model_reset();
        bus.addr_in = 7'h72; bus.we_in = 1'b0;
        #1;
        chk("async_rst_cnt", {24'd0, bus.data_out}, 'h00);
        chk("async_rst_gpio", {24'd0, gpio_out}, 'h00);
        chk("async_rst_irq", {31'd0, irq_out}, 0);
        bus.addr_in = 7'h73;
        #1;
        chk("async_rst_cmp", {24'd0, bus.data_out}, 'hFF);
        rst_in = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
